// File: rtl/odd_parity_fsm_if.sv
// Serial transmit tail bus: frame/bit qualifiers and data going in,
// registered odd-parity bit coming back.
interface odd_parity_fsm_if;
  logic load;
  logic valid;
  logic din;
  logic parity;

  modport master (
    output load,
    output valid,
    output din,
    input  parity
  );

  modport slave (
    input  load,
    input  valid,
    input  din,
    output parity
  );
endinterface

// File: rtl/odd_parity_fsm.sv
// Serial odd-parity generator: two-state Moore FSM tracking whether the count
// of accepted 1s in the current frame is even or odd.
module odd_parity_fsm (
  input  logic              clk,
  input  logic              rst,
  odd_parity_fsm_if.slave   bus
);

  typedef enum logic {
    EVEN_ONES = 1'b0,
    ODD_ONES  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EVEN_ONES;
    end else begin
      state <= state_nxt;
    end
  end

  // load outranks valid: a bit presented alongside load is dropped.
  always_comb begin
    state_nxt  = state;
    bus.parity = 1'b1;
    case (state)
      EVEN_ONES: begin
        bus.parity = 1'b1;
        if (bus.load) begin
          state_nxt = EVEN_ONES;
        end else if (bus.valid && bus.din) begin
          state_nxt = ODD_ONES;
        end
      end
      ODD_ONES: begin
        bus.parity = 1'b0;
        if (bus.load) begin
          state_nxt = EVEN_ONES;
        end else if (bus.valid && bus.din) begin
          state_nxt = EVEN_ONES;
        end
      end
      default: begin
        bus.parity = 1'b1;
        state_nxt  = EVEN_ONES;
      end
    endcase
  end

endmodule

// File: tb/tb_odd_parity_fsm.sv
// Scoreboard bench for odd_parity_fsm: each driven cycle queues the parity
// expected one clock later; each scenario task pops and compares inline.
module tb_odd_parity_fsm;

  logic clk;
  logic rst;
  odd_parity_fsm_if bus ();

  odd_parity_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic got;
  logic want;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  // Apply one cycle of inputs at the falling edge, queue the expected
  // parity, and return just after the rising edge that samples them.
  task automatic drive(input logic r, input logic l, input logic v,
                       input logic d, input logic exp);
    @(negedge clk);
    rst       = r;
    bus.load  = l;
    bus.valid = v;
    bus.din   = d;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [1:0] d_pat;
    d_pat = 2'b10;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      got = bus.parity; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: parity=%b expected %b", i, got, want);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, d_pat[i % 2], 1'b1);
      got = bus.parity; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: parity=%b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_frame_1011;
    logic [3:0] bits;
    logic [3:0] exps;
    bits = 4'b1101;  // bit i sent in order i=0..3 -> 1,0,1,1
    exps = 4'b0100;  // parity after each bit -> 0,0,1,0
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    got = bus.parity; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL frame_load: parity=%b expected %b", got, want);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, bits[i], exps[i]);
      got = bus.parity; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL frame_bit[%0d]: parity=%b expected %b", i, got, want);
      end
      drive(1'b1, 1'b0, 1'b0, ~bits[i], exps[i]);
      got = bus.parity; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL frame_gap[%0d]: parity=%b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_continuation;
    logic [2:0] bits;
    logic [2:0] exps;
    bits = 3'b110;  // 0,1,1
    exps = 3'b010;  // 0,1,0
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < 3; g++) begin
        drive(1'b1, 1'b0, 1'b0, 1'b1, (i == 0) ? 1'b0 : exps[i-1]);
        got = bus.parity; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
          n_err++;
          $display("FAIL cont_gap[%0d.%0d]: parity=%b expected %b", i, g, got, want);
        end
      end
      drive(1'b1, 1'b0, 1'b1, bits[i], exps[i]);
      got = bus.parity; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL cont_bit[%0d]: parity=%b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_load_priority;
    // Enters in ODD_ONES (parity 0) after the continuation frame.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    got = bus.parity; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL load_prio: parity=%b expected %b", got, want);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    got = bus.parity; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL load_prio_hold: parity=%b expected %b", got, want);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    got = bus.parity; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL load_prio_next: parity=%b expected %b", got, want);
    end
  endtask

  task automatic test_valid_gating;
    logic [2:0] exps;
    exps = 3'b010;  // 0,1,0
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    got = bus.parity; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL gate_load: parity=%b expected %b", got, want);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, (i % 2 == 1), 1'b1);
      got = bus.parity; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL gate_idle[%0d]: parity=%b expected %b", i, got, want);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, exps[i]);
      got = bus.parity; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: parity=%b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_reset_midframe;
    // Enters in ODD_ONES (parity 0) after three back-to-back ones.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    got = bus.parity; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL reset_mid: parity=%b expected %b", got, want);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    got = bus.parity; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL reset_mid_hold: parity=%b expected %b", got, want);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    got = bus.parity; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL reset_mid_zero: parity=%b expected %b", got, want);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    got = bus.parity; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL reset_mid_one: parity=%b expected %b", got, want);
    end
  endtask

  initial begin
    rst       = 1'b0;
    bus.load  = 1'b0;
    bus.valid = 1'b0;
    bus.din   = 1'b0;
    test_reset();
    test_frame_1011();
    test_continuation();
    test_load_priority();
    test_valid_gating();
    test_reset_midframe();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: pending=%0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/odd_parity_fsm.md
Name: odd_parity_fsm

Overview:
- Serial odd-parity generator built as a two-state Moore FSM.
- Tracks whether the number of 1s received in the current frame is even or odd.
- Presents the parity bit that makes the total 1-count (data plus parity) odd.
- Sits at the tail of a serial transmit path. Upstream logic marks frame start with load and qualifies each data bit with valid.

Parameters:
- None.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- load  input  1  frame start: clears the accumulated parity state.
- valid  input  1  data qualifier: din is consumed only on edges where valid=1.
- din  input  1  serial data bit.
- parity  output  1  odd-parity bit for all bits accepted since the last load or reset; registered, driven directly from state.

Behaviour:
- States:
  - EVEN_ONES: even count of accepted 1s, including zero.
  - ODD_ONES: odd count of accepted 1s.
- Output decode (Moore, no combinational path from inputs):
  - parity = 1 in EVEN_ONES.
  - parity = 0 in ODD_ONES.
- Reset: on a rising edge with rst=0, state goes to EVEN_ONES and parity reads 1 from the following cycle. Reset overrides load and valid.
- Priority on each rising edge with rst=1: load > valid > hold.
  - load=1: state goes to EVEN_ONES. din and valid are ignored that cycle (the bit is dropped, not counted into the new frame).
  - load=0, valid=1, din=1: state toggles (EVEN_ONES <-> ODD_ONES).
  - load=0, valid=1, din=0: state unchanged.
  - load=0, valid=0: state unchanged, regardless of din.
- Latency: parity reflects a bit one clock after the edge that samples it.
- Back-to-back bits: valid may stay high on consecutive cycles; each cycle is one bit.
- Frame continuation: without a new load, accumulation continues across gaps in valid of any length.
- Reset mid-frame: accumulated state is discarded; parity = 1 next cycle.
- X/Z handling: din is don't-care when valid=0 or load=1.
- State encoding: 1 flip-flop is sufficient. The implementation may add a default/illegal-state recovery branch to EVEN_ONES.

Test Plan:
- Reset: hold rst=0 for 2 cycles with load=0, valid=0, then release -> parity=1 and stays 1 while valid=0.
- Frame 1011: load pulse, then bits 1,0,1,1, each with a single-cycle valid separated by an idle cycle -> parity after each bit = 0, 0, 1, 0.
- Continuation without load: after the frame above, bits 0,1,1 -> parity after each = 0, 1, 0 (cumulative count of 1s is 3, 4, 5).
- Load priority: in ODD_ONES, assert load=1 with valid=1 and din=1 together -> next cycle parity=1 (EVEN_ONES); the din bit is not counted.
- Valid gating: toggle din 0/1 for 5 cycles with valid=0 -> parity unchanged. Then back-to-back valid=1 for 3 cycles with din=1,1,1 -> parity 0, 1, 0 on consecutive cycles.
- Reset mid-frame: from ODD_ONES, pulse rst=0 for one edge while valid=1 and din=1 -> parity=1 next cycle, and the din bit is not counted.
